spell_commit: RTL and testbench
===============================

Name: spell_commit

Overview:
- Architectural-state owner and commit stage for the SPELL stack CPU. It consumes the combinational result bundle produced by the execute stage and registers it.
- Holds pc, sp and the 32-entry data stack. Presents stack_top/stack_belowtop back to execute.
- Issues memory writes over a valid/ready handshake. Sequences the "," delay and the "z" sleep.

Parameters:
- DELAY_PRESCALE, 64, clock cycles per delay unit (>=1); total stall = delay_amount * DELAY_PRESCALE cycles.
- STACK_DEPTH, 32, stack entries; fixed to 2**5 to match the 5-bit sp.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- exec_valid  in  1  execute result bundle valid this cycle
- exec_ready  out  1  commit accepts bundle (state IDLE)
- next_pc  in  8  pc after this instruction
- next_sp  in  5  sp after this instruction
- stack_write_count  in  2  0/1/2 stack entries to write
- set_stack_top  in  8  value for new top
- set_stack_belowtop  in  8  value for new below-top
- memory_write_type  in  2  MemoryTypeNone/Data/Code
- memory_write_addr  in  8  write address
- memory_write_data  in  8  write data
- delay_amount  in  8  delay units, 0 = none
- sleep  in  1  enter sleep
- wake  in  1  leave SLEEP state
- pc  out  8  registered program counter
- sp  out  5  registered stack pointer (next free slot)
- stack_top  out  8  stack[sp-1], combinational read
- stack_belowtop  out  8  stack[sp-2], combinational read
- mem_wr_valid  out  1  memory write request
- mem_wr_ready  in  1  memory accepts request
- mem_wr_type  out  2  held type (Data or Code)
- mem_wr_addr  out  8  held address
- mem_wr_data  out  8  held data
- sleeping  out  1  high in SLEEP

Behaviour:
- Reset: pc=0, sp=0, state=IDLE, mem_wr_valid=0, mem_wr_* = 0, delay counters=0, sleeping=0. Stack contents are not cleared.
- exec_ready = (state==IDLE). A commit happens on a cycle with exec_valid && exec_ready.
- On commit, at the same edge:
  - pc<=next_pc and sp<=next_sp.
  - If stack_write_count>=1: stack[next_sp-1]<=set_stack_top.
  - If stack_write_count==2: stack[next_sp-2]<=set_stack_belowtop.
  - stack_write_count==3 is treated as 2.
  - Indices are mod 32; sp and index arithmetic wrap silently (0-1=31, 31+1=0). No overflow/underflow flag.
- Next state after commit, by priority:
  - memory_write_type!=None -> MEM_WAIT. Latch type/addr/data into mem_wr_*, and mem_wr_valid<=1 on the next cycle.
  - Else delay_amount!=0 -> DELAY. Unit counter<=delay_amount, prescale counter<=DELAY_PRESCALE-1.
  - Else sleep -> SLEEP, sleeping<=1.
  - Else remain IDLE, so back-to-back commits run at 1 per cycle.
- MEM_WAIT:
  - mem_wr_valid=1 and mem_wr_* held stable until handshake.
  - On mem_wr_valid && mem_wr_ready: mem_wr_valid<=0, state->IDLE. Minimum 1 cycle in MEM_WAIT.
- DELAY:
  - Prescale counter decrements each cycle. On reaching 0 it reloads and the unit counter decrements.
  - When the unit counter reaches 0, state->IDLE. exec_ready is low for exactly delay_amount*DELAY_PRESCALE cycles after the commit edge.
- SLEEP:
  - wake high -> IDLE and sleeping<=0 on the next edge.
  - wake at the commit edge itself is ignored; the exit needs wake in SLEEP.
- Stall handling: exec_valid while not ready is ignored. Execute holds its bundle because pc/sp are unchanged.
- stack_top/stack_belowtop read asynchronously from the current sp. After a commit they reflect the new state in the following cycle.
- Reset mid-operation: reset overrides all states, drops mem_wr_valid immediately at the edge, abandons the pending write, and clears delay/sleep.

Decomposition:
- Shared package/include (memtypes): MemoryTypeNone=2'd0, MemoryTypeData=2'd1, MemoryTypeCode=2'd2.
- Commit state encoding IDLE/MEM_WAIT/DELAY/SLEEP, local to this block.
- One sub-module: spell_stack_mem, a 32x8 register array with one combinational read pair (sp-1, sp-2) and two write ports (top, belowtop) applied on the same edge.

Test Plan:
1. Reset, then commit push: next_sp=1, count=1, top=0x41, next_pc=1 -> pc=1, sp=1, stack_top=0x41, exec_ready stays 1.
2. Push 3, push 5, then "+" bundle (next_sp=1, top=8) -> sp=1, stack_top=8. Then "x" with stack [3,5]: count=2, top=3, belowtop=5 -> stack_top=3, stack_belowtop=5.
3. Memory write (type Data, addr 0x10, data 0xAA) with mem_wr_ready low 3 cycles -> mem_wr_valid high 4 cycles, fields stable at 1/0x10/0xAA, exec_ready low until the handshake edge.
4. DELAY_PRESCALE=4, delay_amount=3 -> exec_ready low exactly 12 cycles, then high; pc/sp unchanged throughout.
5. Sleep commit, wake held low 10 cycles -> sleeping=1 and exec_ready=0. Wake pulse -> sleeping=0 and exec_ready=1 next cycle.
6. sp=0, pop bundle with next_sp=31 -> sp=31. Reset asserted during MEM_WAIT -> mem_wr_valid=0, pc=0, sp=0 and exec_ready=1 after the edge.

Source files
------------

// File: rtl/spell_commit_pkg.sv
// Shared definitions for the SPELL commit stage: memory write types and widths.
package spell_commit_pkg;

  typedef enum logic [1:0] {
    MemoryTypeNone = 2'd0,
    MemoryTypeData = 2'd1,
    MemoryTypeCode = 2'd2
  } mem_type_e;

  localparam int STACK_AW = 5;
  localparam int DATA_W   = 8;
  localparam int PC_W     = 8;

endpackage

// File: rtl/spell_stack_mem.sv
// 32x8 data stack: combinational top/below-top read around sp, two write ports on one edge.
module spell_stack_mem
  import spell_commit_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                clock,
  input  logic [STACK_AW-1:0] sp,
  output logic [DATA_W-1:0]   stack_top,
  output logic [DATA_W-1:0]   stack_belowtop,
  input  logic                top_we,
  input  logic [STACK_AW-1:0] top_idx,
  input  logic [DATA_W-1:0]   top_data,
  input  logic                belowtop_we,
  input  logic [STACK_AW-1:0] belowtop_idx,
  input  logic [DATA_W-1:0]   belowtop_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately never reset; the two write indices always differ.
  always_ff @(posedge clock) begin
    if (top_we) begin
      mem[top_idx] <= top_data;
    end
    if (belowtop_we) begin
      mem[belowtop_idx] <= belowtop_data;
    end
  end

  // Index arithmetic wraps modulo the depth through the 5-bit width.
  assign stack_top      = mem[sp - STACK_AW'(1)];
  assign stack_belowtop = mem[sp - STACK_AW'(2)];

endmodule

// File: rtl/spell_commit.sv
// SPELL commit stage: owns pc/sp/stack, issues memory writes and sequences delay and sleep.
module spell_commit
  import spell_commit_pkg::*;
#(
  parameter int DELAY_PRESCALE = 64,
  parameter int STACK_DEPTH    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                exec_valid,
  output logic                exec_ready,
  input  logic [PC_W-1:0]     next_pc,
  input  logic [STACK_AW-1:0] next_sp,
  input  logic [1:0]          stack_write_count,
  input  logic [DATA_W-1:0]   set_stack_top,
  input  logic [DATA_W-1:0]   set_stack_belowtop,
  input  logic [1:0]          memory_write_type,
  input  logic [7:0]          memory_write_addr,
  input  logic [DATA_W-1:0]   memory_write_data,
  input  logic [7:0]          delay_amount,
  input  logic                sleep,
  input  logic                wake,
  output logic [PC_W-1:0]     pc,
  output logic [STACK_AW-1:0] sp,
  output logic [DATA_W-1:0]   stack_top,
  output logic [DATA_W-1:0]   stack_belowtop,
  output logic                mem_wr_valid,
  input  logic                mem_wr_ready,
  output logic [1:0]          mem_wr_type,
  output logic [7:0]          mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic                sleeping
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    DELAY    = 2'd2,
    SLEEP    = 2'd3
  } commit_state_e;

  localparam int PRE_W = (DELAY_PRESCALE > 1) ? $clog2(DELAY_PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(DELAY_PRESCALE - 1);

  commit_state_e       state_reg, state_next;
  logic [PC_W-1:0]     pc_reg, pc_next;
  logic [STACK_AW-1:0] sp_reg, sp_next;
  logic                mem_wr_valid_reg, mem_wr_valid_next;
  logic [1:0]          mem_wr_type_reg, mem_wr_type_next;
  logic [7:0]          mem_wr_addr_reg, mem_wr_addr_next;
  logic [DATA_W-1:0]   mem_wr_data_reg, mem_wr_data_next;
  logic [7:0]          unit_cnt_reg, unit_cnt_next;
  logic [PRE_W-1:0]    pre_cnt_reg, pre_cnt_next;
  logic                sleeping_reg, sleeping_next;
  logic                commit;

  assign exec_ready = (state_reg == IDLE);
  assign commit     = exec_valid && exec_ready;

  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    sp_next           = sp_reg;
    mem_wr_valid_next = mem_wr_valid_reg;
    mem_wr_type_next  = mem_wr_type_reg;
    mem_wr_addr_next  = mem_wr_addr_reg;
    mem_wr_data_next  = mem_wr_data_reg;
    unit_cnt_next     = unit_cnt_reg;
    pre_cnt_next      = pre_cnt_reg;
    sleeping_next     = sleeping_reg;
    case (state_reg)
      IDLE: begin
        if (commit) begin
          pc_next = next_pc;
          sp_next = next_sp;
          // Memory write outranks delay, which outranks sleep.
          if (memory_write_type != MemoryTypeNone) begin
            state_next        = MEM_WAIT;
            mem_wr_valid_next = 1'b1;
            mem_wr_type_next  = memory_write_type;
            mem_wr_addr_next  = memory_write_addr;
            mem_wr_data_next  = memory_write_data;
          end else if (delay_amount != 8'd0) begin
            state_next    = DELAY;
            unit_cnt_next = delay_amount;
            pre_cnt_next  = PRE_LOAD;
          end else if (sleep) begin
            state_next    = SLEEP;
            sleeping_next = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_wr_valid_reg && mem_wr_ready) begin
          mem_wr_valid_next = 1'b0;
          state_next        = IDLE;
        end
      end
      DELAY: begin
        if (pre_cnt_reg == '0) begin
          pre_cnt_next  = PRE_LOAD;
          unit_cnt_next = unit_cnt_reg - 8'd1;
          if (unit_cnt_reg == 8'd1) begin
            state_next = IDLE;
          end
        end else begin
          pre_cnt_next = pre_cnt_reg - PRE_W'(1);
        end
      end
      SLEEP: begin
        if (wake) begin
          state_next    = IDLE;
          sleeping_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      pc_reg           <= '0;
      sp_reg           <= '0;
      mem_wr_valid_reg <= 1'b0;
      mem_wr_type_reg  <= MemoryTypeNone;
      mem_wr_addr_reg  <= '0;
      mem_wr_data_reg  <= '0;
      unit_cnt_reg     <= '0;
      pre_cnt_reg      <= '0;
      sleeping_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      sp_reg           <= sp_next;
      mem_wr_valid_reg <= mem_wr_valid_next;
      mem_wr_type_reg  <= mem_wr_type_next;
      mem_wr_addr_reg  <= mem_wr_addr_next;
      mem_wr_data_reg  <= mem_wr_data_next;
      unit_cnt_reg     <= unit_cnt_next;
      pre_cnt_reg      <= pre_cnt_next;
      sleeping_reg     <= sleeping_next;
    end
  end

  spell_stack_mem #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clock         (clock),
    .sp            (sp_reg),
    .stack_top     (stack_top),
    .stack_belowtop(stack_belowtop),
    .top_we        (commit && (stack_write_count != 2'd0)),
    .top_idx       (next_sp - STACK_AW'(1)),
    .top_data      (set_stack_top),
    .belowtop_we   (commit && stack_write_count[1]),
    .belowtop_idx  (next_sp - STACK_AW'(2)),
    .belowtop_data (set_stack_belowtop)
  );

  assign pc           = pc_reg;
  assign sp           = sp_reg;
  assign mem_wr_valid = mem_wr_valid_reg;
  assign mem_wr_type  = mem_wr_type_reg;
  assign mem_wr_addr  = mem_wr_addr_reg;
  assign mem_wr_data  = mem_wr_data_reg;
  assign sleeping     = sleeping_reg;

endmodule

// File: tb/tb_spell_commit.sv
// Directed bench for spell_commit: pushes, swap, memory handshake, delay, sleep, wrap and reset.
module tb_spell_commit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       exec_valid = 1'b0;
  logic       exec_ready;
  logic [7:0] next_pc = '0;
  logic [4:0] next_sp = '0;
  logic [1:0] stack_write_count = '0;
  logic [7:0] set_stack_top = '0;
  logic [7:0] set_stack_belowtop = '0;
  logic [1:0] memory_write_type = '0;
  logic [7:0] memory_write_addr = '0;
  logic [7:0] memory_write_data = '0;
  logic [7:0] delay_amount = '0;
  logic       sleep = 1'b0;
  logic       wake = 1'b0;
  logic [7:0] pc;
  logic [4:0] sp;
  logic [7:0] stack_top;
  logic [7:0] stack_belowtop;
  logic       mem_wr_valid;
  logic       mem_wr_ready = 1'b0;
  logic [1:0] mem_wr_type;
  logic [7:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       sleeping;

  int n_cmp = 0;
  int n_err = 0;

  spell_commit #(
    .DELAY_PRESCALE(4),
    .STACK_DEPTH   (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .exec_valid        (exec_valid),
    .exec_ready        (exec_ready),
    .next_pc           (next_pc),
    .next_sp           (next_sp),
    .stack_write_count (stack_write_count),
    .set_stack_top     (set_stack_top),
    .set_stack_belowtop(set_stack_belowtop),
    .memory_write_type (memory_write_type),
    .memory_write_addr (memory_write_addr),
    .memory_write_data (memory_write_data),
    .delay_amount      (delay_amount),
    .sleep             (sleep),
    .wake              (wake),
    .pc                (pc),
    .sp                (sp),
    .stack_top         (stack_top),
    .stack_belowtop    (stack_belowtop),
    .mem_wr_valid      (mem_wr_valid),
    .mem_wr_ready      (mem_wr_ready),
    .mem_wr_type       (mem_wr_type),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_data       (mem_wr_data),
    .sleeping          (sleeping)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one bundle for a single edge, then withdraw it.
  task automatic commit(input logic [7:0] npc, input logic [4:0] nsp, input logic [1:0] cnt,
                        input logic [7:0] top, input logic [7:0] below, input logic [1:0] mt,
                        input logic [7:0] ma, input logic [7:0] md, input logic [7:0] dly,
                        input logic slp);
    exec_valid = 1'b1;
    next_pc = npc;
    next_sp = nsp;
    stack_write_count = cnt;
    set_stack_top = top;
    set_stack_belowtop = below;
    memory_write_type = mt;
    memory_write_addr = ma;
    memory_write_data = md;
    delay_amount = dly;
    sleep = slp;
    step();
    exec_valid = 1'b0;
    stack_write_count = 2'd0;
    memory_write_type = 2'd0;
    delay_amount = 8'd0;
    sleep = 1'b0;
  endtask

  initial begin
    int cyc;
    logic held_ok;

    step();
    step();
    reset = 1'b0;
    check("reset_pc", 32'(pc), 0);
    check("reset_sp", 32'(sp), 0);
    check("reset_ready", 32'(exec_ready), 1);
    check("reset_valid", 32'(mem_wr_valid), 0);
    check("reset_sleeping", 32'(sleeping), 0);

    // Single push
    commit(8'd1, 5'd1, 2'd1, 8'h41, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    check("push_pc", 32'(pc), 1);
    check("push_sp", 32'(sp), 1);
    check("push_top", 32'(stack_top), 'h41);
    check("push_ready", 32'(exec_ready), 1);

    // Push 3, push 5, add
    commit(8'd2, 5'd2, 2'd1, 8'd3, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    commit(8'd3, 5'd3, 2'd1, 8'd5, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    check("push5_belowtop", 32'(stack_belowtop), 3);
    commit(8'd4, 5'd2, 2'd1, 8'd8, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    check("add_sp", 32'(sp), 2);
    check("add_top", 32'(stack_top), 8);
    check("add_belowtop", 32'(stack_belowtop), 'h41);

    // Push 3, push 5, swap with a two-entry write
    commit(8'd5, 5'd3, 2'd1, 8'd3, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    commit(8'd6, 5'd4, 2'd1, 8'd5, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    commit(8'd7, 5'd4, 2'd2, 8'd3, 8'd5, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    check("swap_top", 32'(stack_top), 3);
    check("swap_belowtop", 32'(stack_belowtop), 5);
    check("swap_sp", 32'(sp), 4);

    // Memory write with ready held low for three cycles
    mem_wr_ready = 1'b0;
    commit(8'd8, 5'd4, 2'd0, 8'h00, 8'h00, 2'd1, 8'h10, 8'hAA, 8'd0, 1'b0);
    cyc = 0;
    held_ok = 1'b1;
    while (mem_wr_valid && cyc < 20) begin
      if (mem_wr_type != 2'd1 || mem_wr_addr != 8'h10 || mem_wr_data != 8'hAA || exec_ready)
        held_ok = 1'b0;
      cyc++;
      if (cyc == 4) mem_wr_ready = 1'b1;
      step();
    end
    mem_wr_ready = 1'b0;
    check("memw_valid_cycles", 32'(cyc), 4);
    check("memw_fields_held", 32'(held_ok), 1);
    check("memw_ready_after", 32'(exec_ready), 1);
    check("memw_pc", 32'(pc), 8);

    // Delay of 3 units at prescale 4; a stalled bundle must be ignored meanwhile
    commit(8'd9, 5'd4, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd3, 1'b0);
    exec_valid = 1'b1;
    next_pc = 8'h99;
    next_sp = 5'd17;
    cyc = 0;
    held_ok = 1'b1;
    while (!exec_ready && cyc < 50) begin
      if (pc != 8'd9 || sp != 5'd4) held_ok = 1'b0;
      cyc++;
      step();
    end
    exec_valid = 1'b0;
    check("delay_stall_cycles", 32'(cyc), 12);
    check("delay_state_held", 32'(held_ok), 1);
    check("delay_pc_after", 32'(pc), 9);

    // Sleep for 10 cycles then wake
    commit(8'd10, 5'd4, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b1);
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!sleeping || exec_ready) held_ok = 1'b0;
      step();
    end
    check("sleep_held", 32'(held_ok), 1);
    wake = 1'b1;
    step();
    wake = 1'b0;
    check("wake_sleeping", 32'(sleeping), 0);
    check("wake_ready", 32'(exec_ready), 1);

    // Wake coincident with the sleep commit is ignored
    wake = 1'b1;
    commit(8'd11, 5'd4, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b1);
    check("wake_at_commit_sleeping", 32'(sleeping), 1);
    step();
    wake = 1'b0;
    check("wake_late_sleeping", 32'(sleeping), 0);

    // sp wrap-around: pop from 0, push back to 0
    commit(8'd12, 5'd0, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    commit(8'd13, 5'd31, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    check("wrap_pop_sp", 32'(sp), 31);
    commit(8'd14, 5'd0, 2'd1, 8'h77, 8'h00, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    check("wrap_push_sp", 32'(sp), 0);
    check("wrap_push_top", 32'(stack_top), 'h77);

    // Reset in the middle of a pending write
    commit(8'd15, 5'd0, 2'd0, 8'h00, 8'h00, 2'd2, 8'h20, 8'h55, 8'd0, 1'b0);
    step();
    check("pend_valid", 32'(mem_wr_valid), 1);
    check("pend_type", 32'(mem_wr_type), 2);
    reset = 1'b1;
    step();
    check("rst_mid_valid", 32'(mem_wr_valid), 0);
    check("rst_mid_pc", 32'(pc), 0);
    check("rst_mid_sp", 32'(sp), 0);
    check("rst_mid_ready", 32'(exec_ready), 1);
    reset = 1'b0;
    step();
    check("post_rst_valid", 32'(mem_wr_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
